// File: rtl/check_gen.sv
// rtl/check_gen.sv - folds ITERATIONS samples into an expected value per start and checks DUT results from a FIFO
// Optional messages: define CHECK_GEN_MSG_EN to print passes and report errors at simulation time.
`ifndef MAGIC_NUMBER
`define MAGIC_NUMBER 4
`endif

module check_gen #(
  parameter int WIDTH      = 8,
  parameter int ITERATIONS = `MAGIC_NUMBER,
  parameter int DEPTH      = 4,
  parameter int MODE       = 0,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         start,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         valid,
  input  logic [WIDTH-1:0]             data_out,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic [CNT_W-1:0]             pass_count,
  output logic [CNT_W-1:0]             fail_count,
  output logic                         err,
  output logic                         overflow,
  output logic                         unexpected,
  output logic                         timeout
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(ITERATIONS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] SEED = (MODE == 0) ? WIDTH'(1) : '0;

  typedef enum logic [1:0] {IDLE, ACCUM, PUSH} state_t;

  state_t            state;
  logic [WIDTH-1:0]  acc;
  logic [IW-1:0]     iter;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [TW-1:0]     tcnt;

  logic full, empty, do_push, do_pop, drop, mismatch, stray, tcnt_run, tcnt_hit;

  // Full is judged on the registered occupancy, so a same-cycle pop never frees room for the push.
  assign full     = (pending == PW'(DEPTH));
  assign empty    = (pending == '0);
  assign do_push  = (state == PUSH) && !full;
  assign drop     = (state == PUSH) && full;
  assign do_pop   = valid && !empty;
  assign mismatch = do_pop && (data_out != mem[rd_ptr]);
  assign stray    = valid && empty;
  assign tcnt_run = !empty && !valid && (tcnt != TW'(TIMEOUT));
  assign tcnt_hit = tcnt_run && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      acc   <= SEED;
      iter  <= '0;
    end else if (clr) begin
      state <= IDLE;
      busy  <= 1'b0;
      acc   <= SEED;
      iter  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc   <= SEED;
          iter  <= '0;
          state <= ACCUM;
          busy  <= 1'b1;
        end
        ACCUM: begin
          acc  <= (MODE == 0) ? acc * data_in : acc + data_in;
          iter <= iter + 1'b1;
          if (iter == IW'(ITERATIONS - 1)) state <= PUSH;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pending    <= '0;
      tcnt       <= '0;
      pass_count <= '0;
      fail_count <= '0;
      err        <= 1'b0;
      overflow   <= 1'b0;
      unexpected <= 1'b0;
      timeout    <= 1'b0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pending    <= '0;
      tcnt       <= '0;
      pass_count <= '0;
      fail_count <= '0;
      err        <= 1'b0;
      overflow   <= 1'b0;
      unexpected <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      pending <= pending + 1'b1;
      else if (!do_push && do_pop) pending <= pending - 1'b1;

      if (do_pop && !mismatch && pass_count != '1) pass_count <= pass_count + 1'b1;
      if ((mismatch || stray) && fail_count != '1) fail_count <= fail_count + 1'b1;
      if (mismatch) err        <= 1'b1;
      if (stray)    unexpected <= 1'b1;
      if (drop)     overflow   <= 1'b1;

      if (do_pop || empty) tcnt <= '0;
      else if (tcnt_run)   tcnt <= tcnt + 1'b1;
      if (tcnt_hit) timeout <= 1'b1;
    end
  end

`ifdef CHECK_GEN_MSG_EN
  always @(posedge clk) begin
    if (rst_n && !clr) begin
      if (do_pop && !mismatch) $write(".");
      if (mismatch)
        $error("check_gen: expected %0h data_out %0h pass %0d fail %0d",
               mem[rd_ptr], data_out, pass_count, fail_count);
      if (stray && !unexpected) $error("check_gen: valid with no expected value queued");
      if (drop && !overflow)    $error("check_gen: expected value dropped, FIFO full");
      if (tcnt_hit && !timeout) $error("check_gen: timeout waiting for valid");
    end
  end
`endif

endmodule

// File: tb/tb_check_gen.sv
// tb/tb_check_gen.sv - scoreboard bench for check_gen (multiply and add instances)
module tb_check_gen;

  logic       clk = 1'b0;
  logic       rst_n, clr, start;
  logic [7:0] data_in;
  logic       valid0, valid1;
  logic [7:0] data_out0, data_out1;

  logic        busy0, err0, ovf0, unx0, to0;
  logic [2:0]  pending0;
  logic [15:0] pass0, fail0;
  logic        busy1, err1, ovf1, unx1, to1;
  logic [2:0]  pending1;
  logic [1:0]  pass1, fail1;

  always #5 clk = ~clk;

  check_gen #(.WIDTH(8), .ITERATIONS(4), .DEPTH(4), .MODE(0), .TIMEOUT(64), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .data_in(data_in),
    .valid(valid0), .data_out(data_out0), .busy(busy0), .pending(pending0),
    .pass_count(pass0), .fail_count(fail0), .err(err0), .overflow(ovf0),
    .unexpected(unx0), .timeout(to0));

  check_gen #(.WIDTH(8), .ITERATIONS(4), .DEPTH(4), .MODE(1), .TIMEOUT(64), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .data_in(data_in),
    .valid(valid1), .data_out(data_out1), .busy(busy1), .pending(pending1),
    .pass_count(pass1), .fail_count(fail1), .err(err1), .overflow(ovf1),
    .unexpected(unx1), .timeout(to1));

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb_q[$];
  logic [7:0] sb1_q[$];
  int exp_pass, exp_fail;
  bit exp_err, exp_ovf, exp_unx, exp_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] fold(input bit add, input logic [7:0] a, b, c, d);
    logic [7:0] r;
    if (add) begin
      r = a + b; r = r + c; r = r + d;
    end else begin
      r = a * b; r = r * c; r = r * d;
    end
    return r;
  endfunction

  task automatic clear_model();
    sb_q.delete();
    sb1_q.delete();
    exp_pass = 0; exp_fail = 0;
    exp_err = 0; exp_ovf = 0; exp_unx = 0; exp_to = 0;
  endtask

  task automatic check_dut0(input string tag);
    check({tag, ".busy"},    32'(busy0),    32'(0));
    check({tag, ".pending"}, 32'(pending0), 32'(sb_q.size()));
    check({tag, ".pass"},    32'(pass0),    32'(exp_pass));
    check({tag, ".fail"},    32'(fail0),    32'(exp_fail));
    check({tag, ".err"},     32'(err0),     32'(exp_err));
    check({tag, ".ovf"},     32'(ovf0),     32'(exp_ovf));
    check({tag, ".unx"},     32'(unx0),     32'(exp_unx));
    check({tag, ".to"},      32'(to0),      32'(exp_to));
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    clear_model();
  endtask

  task automatic run_txn(input logic [7:0] a, b, c, d, input bit pop_at_push);
    logic [7:0] e0, e1, h;
    bit full0, full1;
    e0 = fold(1'b0, a, b, c, d);
    e1 = fold(1'b1, a, b, c, d);
    start = 1'b1;
    step();
    start = 1'b0;
    data_in = a; step();
    data_in = b; step();
    data_in = c; step();
    data_in = d; step();
    check("pre_push.pending", 32'(pending0), 32'(sb_q.size()));
    check("pre_push.busy", 32'(busy0), 32'(1));
    full0 = (sb_q.size() >= 4);
    full1 = (sb1_q.size() >= 4);
    if (pop_at_push) begin
      h = sb_q.pop_front();
      valid0 = 1'b1;
      data_out0 = h;
      exp_pass++;
    end
    if (!full0) sb_q.push_back(e0); else exp_ovf = 1;
    if (!full1) sb1_q.push_back(e1);
    step();
    valid0 = 1'b0;
  endtask

  task automatic pop0(input bit corrupt);
    logic [7:0] h;
    h = sb_q.pop_front();
    valid0 = 1'b1;
    data_out0 = corrupt ? (h ^ 8'h01) : h;
    if (corrupt) begin exp_fail++; exp_err = 1; end
    else exp_pass++;
    step();
    valid0 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; start = 1'b0; data_in = '0;
    valid0 = 1'b0; valid1 = 1'b0; data_out0 = '0; data_out1 = '0;
    clear_model();
    step(); step();
    check_dut0("reset");
    rst_n = 1'b1;
    step();

    // multiply fold, pass then mismatch
    run_txn(8'd2, 8'd3, 8'd1, 8'd2, 1'b0);
    check("t1.head", 32'(sb_q[0]), 32'h0C);
    check_dut0("t1.queued");
    pop0(1'b0);
    check_dut0("t1.pass");
    run_txn(8'd5, 8'd5, 8'd5, 8'd5, 1'b0);
    pop0(1'b1);
    check_dut0("t1.mismatch");

    // overflow, full-before-pop, and drain
    do_clr();
    check_dut0("clr");
    for (int i = 0; i < 5; i++)
      run_txn(8'(i + 1), 8'(i + 3), 8'($urandom_range(0, 255)), 8'(2 * i + 1), 1'b0);
    check_dut0("ovf.full");
    run_txn(8'd7, 8'd9, 8'd11, 8'd13, 1'b1);
    check_dut0("ovf.push_pop_full");
    pop0(1'b0);
    run_txn(8'd4, 8'd4, 8'd2, 8'd3, 1'b1);
    check_dut0("push_pop_same");
    while (sb_q.size() > 0) pop0(1'b0);
    check_dut0("ovf.drain");

    // valid with empty FIFO
    do_clr();
    valid0 = 1'b1; data_out0 = 8'h5A;
    exp_fail++; exp_unx = 1;
    step();
    valid0 = 1'b0;
    check_dut0("unexpected");

    // timeout at exactly 64 waiting cycles
    do_clr();
    run_txn(8'd3, 8'd3, 8'd3, 8'd3, 1'b0);
    for (int i = 0; i < 63; i++) step();
    check("to.63", 32'(to0), 32'(0));
    step();
    check("to.64", 32'(to0), 32'(1));
    do_clr();
    check_dut0("to.clr");

    // reset during the second ACCUM cycle
    start = 1'b1; step(); start = 1'b0;
    data_in = 8'd2; step();
    rst_n = 1'b0;
    #1;
    check("rst_mid.busy", 32'(busy0), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_model();
    step(); step(); step();
    check_dut0("rst_mid.idle");
    run_txn(8'd6, 8'd7, 8'd1, 8'd1, 1'b0);
    pop0(1'b0);
    check_dut0("rst_mid.clean");

    // add mode: pass, wrap mismatch, saturating fail counter
    do_clr();
    run_txn(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    valid1 = 1'b1; data_out1 = sb1_q.pop_front(); step(); valid1 = 1'b0;
    check("add.pass", 32'(pass1), 32'(1));
    check("add.pass_val", 32'(data_out1), 32'h0A);
    run_txn(8'h80, 8'h80, 8'h80, 8'h80, 1'b0);
    valid1 = 1'b1; data_out1 = 8'h01; step(); valid1 = 1'b0;
    check("wrap.fail", 32'(fail1), 32'(1));
    check("wrap.err", 32'(err1), 32'(1));
    check("wrap.pending", 32'(pending1), 32'(0));
    pop0(1'b0);
    pop0(1'b0);
    check_dut0("add.dut0");
    for (int i = 0; i < 4; i++) begin
      valid1 = 1'b1; data_out1 = 8'h33; step();
    end
    valid1 = 1'b0;
    check("sat.fail", 32'(fail1), 32'(3));
    check("sat.unx", 32'(unx1), 32'(1));
    check("sat.pass", 32'(pass1), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
